// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: instruction-bus request/response plus the decode-side
// stall/redirect controls and the fetched-instruction output.
interface fetch_stage_if #(parameter int XLEN = 64);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
  } fetch_data_t;

  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  fetch_data_t     dataF;
  logic            dataF_valid;

  modport master (
    output ireq_valid, ireq_addr, dataF, dataF_valid,
    input  iresp_data_ok, iresp_data, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  ireq_valid, ireq_addr, dataF, dataF_valid,
    output iresp_data_ok, iresp_data, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one bus request in flight, and buffers
// returned words in an output register backed by a one-entry skid register.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN+31:0]  dataf_q, dataf_d;
  logic              dataf_valid_q, dataf_valid_d;
  logic [XLEN+31:0]  skid_q, skid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              consume;
  logic [XLEN-1:0]   pc_inc;

  assign consume = dataf_valid_q && !fif.stall;
  assign pc_inc  = pc_q + XLEN'(4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    dataf_d       = dataf_q;
    dataf_valid_d = dataf_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;

    if (fif.redirect_valid) begin
      dataf_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      pc_d          = fif.redirect_pc;
      case (state_q)
        S_IDLE: begin
          state_d    = S_WAIT;
          req_addr_d = fif.redirect_pc;
        end
        // A DRAIN response arriving with a redirect also closes the stale
        // request, so restart immediately instead of waiting forever.
        S_WAIT, S_DRAIN: begin
          if (fif.iresp_data_ok) begin
            state_d    = S_WAIT;
            req_addr_d = fif.redirect_pc;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      if (consume) begin
        dataf_valid_d = skid_valid_q;
        dataf_d       = skid_q;
        skid_valid_d  = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (!skid_valid_d) begin
            state_d    = S_WAIT;
            req_addr_d = pc_q;
          end
        end
        // Skid is always empty in WAIT: issue requires it and redirects flush it.
        S_WAIT: begin
          if (fif.iresp_data_ok) begin
            if (!dataf_valid_q || consume) begin
              dataf_d       = {req_addr_q, fif.iresp_data};
              dataf_valid_d = 1'b1;
            end else begin
              skid_d       = {req_addr_q, fif.iresp_data};
              skid_valid_d = 1'b1;
            end
            pc_d = pc_inc;
            if (!skid_valid_d) begin
              state_d    = S_WAIT;
              req_addr_d = pc_inc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (fif.iresp_data_ok) begin
            state_d    = S_WAIT;
            req_addr_d = pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RESET;
      req_addr_q    <= PC_RESET;
      dataf_q       <= '0;
      dataf_valid_q <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      dataf_q       <= dataf_d;
      dataf_valid_q <= dataf_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  assign fif.ireq_valid  = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign fif.ireq_addr   = req_addr_q;
  assign fif.dataF       = dataf_q;
  assign fif.dataF_valid = dataf_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus hand-written reset sequences.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(64)) fif();

  fetch_stage #(.XLEN(64), .PC_RESET(64'h8000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  typedef struct {
    logic        stall;
    logic        ok;
    logic [31:0] data;
    logic        redir;
    logic [63:0] rpc;
    logic        ev;
    logic [63:0] ea;
    logic        edv;
    logic [63:0] epc;
    logic [31:0] ei;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(logic stall, logic ok, logic [31:0] data, logic redir,
                              logic [63:0] rpc, logic ev, logic [63:0] ea,
                              logic edv, logic [63:0] epc, logic [31:0] ei);
    vec_t v;
    v.stall = stall; v.ok = ok; v.data = data; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.ea = ea; v.edv = edv; v.epc = epc; v.ei = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic ok, input logic [31:0] data,
                       input logic redir, input logic [63:0] rpc);
    fif.stall          = stall;
    fif.iresp_data_ok  = ok;
    fif.iresp_data     = data;
    fif.redirect_valid = redir;
    fif.redirect_pc    = rpc;
  endtask

  initial begin
    localparam logic [63:0] B = 64'h8000_0000;
    localparam logic [63:0] C = 64'h8000_1000;
    localparam logic [63:0] T = 64'h8000_3000;
    localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;

    //              stall ok data          rd rpc            ev ea        edv epc      ei
    vecs[0]  = mk(0, 0, 32'h0,        0, 64'h0,          0, B,        0, 0,      0);
    vecs[1]  = mk(0, 1, 32'h13,       0, 64'h0,          1, B,        0, 0,      0);
    vecs[2]  = mk(0, 1, 32'h13,       0, 64'h0,          1, B+4,      1, B,      32'h13);
    vecs[3]  = mk(0, 1, 32'h13,       0, 64'h0,          1, B+8,      1, B+4,    32'h13);
    vecs[4]  = mk(0, 0, 32'h0,        0, 64'h0,          1, B+12,     1, B+8,    32'h13);
    vecs[5]  = mk(0, 0, 32'h0,        0, 64'h0,          1, B+12,     0, 0,      0);
    vecs[6]  = mk(0, 1, 32'hDEADBEEF, 0, 64'h0,          1, B+12,     0, 0,      0);
    vecs[7]  = mk(1, 0, 32'h0,        0, 64'h0,          1, B+16,     1, B+12,   32'hDEADBEEF);
    vecs[8]  = mk(1, 1, 32'h11111111, 0, 64'h0,          1, B+16,     1, B+12,   32'hDEADBEEF);
    vecs[9]  = mk(1, 0, 32'h0,        0, 64'h0,          0, B+16,     1, B+12,   32'hDEADBEEF);
    vecs[10] = mk(1, 0, 32'h0,        0, 64'h0,          0, B+16,     1, B+12,   32'hDEADBEEF);
    vecs[11] = mk(0, 0, 32'h0,        0, 64'h0,          0, B+16,     1, B+12,   32'hDEADBEEF);
    vecs[12] = mk(0, 0, 32'h0,        0, 64'h0,          1, B+20,     1, B+16,   32'h11111111);
    vecs[13] = mk(0, 1, 32'h22222222, 0, 64'h0,          1, B+20,     0, 0,      0);
    vecs[14] = mk(0, 0, 32'h0,        0, 64'h0,          1, B+24,     1, B+20,   32'h22222222);
    vecs[15] = mk(0, 0, 32'h0,        1, C,              1, B+24,     0, 0,      0);
    vecs[16] = mk(0, 0, 32'h0,        0, 64'h0,          1, B+24,     0, 0,      0);
    vecs[17] = mk(0, 1, 32'hBAD0BAD0, 0, 64'h0,          1, B+24,     0, 0,      0);
    vecs[18] = mk(0, 0, 32'h0,        0, 64'h0,          1, C,        0, 0,      0);
    vecs[19] = mk(0, 1, 32'h33333333, 0, 64'h0,          1, C,        0, 0,      0);
    vecs[20] = mk(1, 0, 32'h0,        0, 64'h0,          1, C+4,      1, C,      32'h33333333);
    vecs[21] = mk(1, 1, 32'h44444444, 0, 64'h0,          1, C+4,      1, C,      32'h33333333);
    vecs[22] = mk(1, 0, 32'h0,        0, 64'h0,          0, C+4,      1, C,      32'h33333333);
    vecs[23] = mk(1, 0, 32'h0,        1, 64'h8000_2000,  0, C+4,      1, C,      32'h33333333);
    vecs[24] = mk(0, 1, 32'h55555555, 1, T,              1, 64'h8000_2000, 0, 0, 0);
    vecs[25] = mk(0, 0, 32'h0,        0, 64'h0,          1, T,        0, 0,      0);
    vecs[26] = mk(0, 1, 32'h66666666, 0, 64'h0,          1, T,        0, 0,      0);
    vecs[27] = mk(0, 0, 32'h0,        0, 64'h0,          1, T+4,      1, T,      32'h66666666);
    vecs[28] = mk(0, 0, 32'h0,        1, W,              1, T+4,      0, 0,      0);
    vecs[29] = mk(0, 1, 32'h77777777, 0, 64'h0,          1, T+4,      0, 0,      0);
    vecs[30] = mk(0, 1, 32'h88888888, 0, 64'h0,          1, W,        0, 0,      0);
    vecs[31] = mk(0, 0, 32'h0,        0, 64'h0,          1, 64'h0,    1, W,      32'h88888888);

    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ireq_valid", {63'h0, fif.ireq_valid}, 64'h0);
    check("rst_ireq_addr", fif.ireq_addr, B);
    check("rst_dataF_valid", {63'h0, fif.dataF_valid}, 64'h0);
    check("rst_dataF_pc", fif.dataF.pc, 64'h0);
    check("rst_dataF_instr", {32'h0, fif.dataF.instruction}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].stall, vecs[i].ok, vecs[i].data, vecs[i].redir, vecs[i].rpc);
      #1;
      check($sformatf("v%0d_ireq_valid", i), {63'h0, fif.ireq_valid}, {63'h0, vecs[i].ev});
      check($sformatf("v%0d_ireq_addr", i), fif.ireq_addr, vecs[i].ea);
      check($sformatf("v%0d_dataF_valid", i), {63'h0, fif.dataF_valid}, {63'h0, vecs[i].edv});
      if (vecs[i].edv) begin
        check($sformatf("v%0d_dataF_pc", i), fif.dataF.pc, vecs[i].epc);
        check($sformatf("v%0d_dataF_instr", i), {32'h0, fif.dataF.instruction}, {32'h0, vecs[i].ei});
      end
      @(negedge clk);
    end

    // Request to address 0 is outstanding; assert reset away from any clock edge.
    drive(0, 0, 32'h0, 0, 64'h0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ireq_valid", {63'h0, fif.ireq_valid}, 64'h0);
    check("async_rst_dataF_valid", {63'h0, fif.dataF_valid}, 64'h0);
    check("async_rst_ireq_addr", fif.ireq_addr, B);
    drive(0, 1, 32'h99999999, 0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("late_ok_ireq_valid", {63'h0, fif.ireq_valid}, 64'h0);
    check("late_ok_dataF_valid", {63'h0, fif.dataF_valid}, 64'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 64'h0);
    #1;
    check("post_rst_ireq_valid", {63'h0, fif.ireq_valid}, 64'h1);
    check("post_rst_ireq_addr", fif.ireq_addr, B);
    check("post_rst_dataF_valid", {63'h0, fif.dataF_valid}, 64'h0);
    @(negedge clk);
    #1;
    check("post_rst_held_addr", fif.ireq_addr, B);
    check("post_rst_still_empty", {63'h0, fif.dataF_valid}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
